rx_freq_sched: RTL and testbench

Config sequencer for the DDC and waterfall tuning registers in the cpu_clk domain. It arbitrates between two requesters, RX-audio retune and waterfall retune, and replays each request as the fixed strobe sequence the receiver expects:

1. Channel select.
2. Freeze TOS, then wait for sync, then write freq high word.
3. Freeze TOS, then wait for sync, then write freq low word.

This removes per-retune instruction sequences from the ecpu and guarantees the frozen-TOS crossing has settled before each write strobe.

---
 rtl/rx_freq_sched_if.sv | 13 +
 rtl/rx_freq_sched.sv | 143 ++++++++++++++
 tb/tb_rx_freq_sched.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_freq_sched_if.sv
// Requester bundle for rx_freq_sched: level request, channel, phase
// increment and the one-cycle completion pulse.
interface rx_freq_sched_if #(
    parameter int CHAN_BITS = 3
);
    logic                 req;
    logic [CHAN_BITS-1:0] chan;
    logic [47:0]          freq;
    logic                 ack;

    modport master (output req, chan, freq, input ack);
    modport slave  (input req, chan, freq, output ack);
endinterface

// File: rtl/rx_freq_sched.sv
// Retune sequencer: arbitrates RX and waterfall requests and replays each
// as channel select, frozen-TOS high word write, frozen-TOS low word write.
module rx_freq_sched #(
    parameter int CHAN_BITS = 3,
    parameter int SYNC_GAP  = 4
) (
    input  logic           cpu_clk,
    input  logic           rst_n,
    rx_freq_sched_if.slave rx,
    rx_freq_sched_if.slave wf,
    output logic [31:0]    tos_o,
    output logic           kind_o,
    output logic           set_chan_o,
    output logic           freeze_o,
    output logic           set_freqH_o,
    output logic           set_freqL_o,
    output logic           busy
);

    typedef enum logic [3:0] {
        IDLE, SEL, FRZ_H, WAIT_H, WR_H, FRZ_L, WAIT_L, WR_L, ACK
    } state_e;

    localparam logic       KIND_RX = 1'b0;
    localparam logic       KIND_WF = 1'b1;
    localparam logic [3:0] GAP_M1  = 4'(SYNC_GAP - 1);

    state_e               state_q, state_d;
    logic                 kind_q, kind_d;
    logic                 last_q, last_d;
    logic [CHAN_BITS-1:0] chan_q, chan_d;
    logic [47:0]          freq_q, freq_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 grant_wf;
    logic                 rx_ack_c, wf_ack_c;

    // WF wins only when RX is absent or RX was the last one served
    assign grant_wf = wf.req & (~rx.req | (last_q == KIND_RX));

    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            kind_q  <= KIND_RX;
            last_q  <= KIND_WF;
            chan_q  <= '0;
            freq_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            last_q  <= last_d;
            chan_q  <= chan_d;
            freq_q  <= freq_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        last_d  = last_q;
        chan_d  = chan_q;
        freq_d  = freq_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (rx.req | wf.req) begin
                    state_d = SEL;
                    kind_d  = grant_wf;
                    last_d  = grant_wf;
                    chan_d  = grant_wf ? wf.chan : rx.chan;
                    freq_d  = grant_wf ? wf.freq : rx.freq;
                end
            end
            SEL:   state_d = FRZ_H;
            FRZ_H: begin
                state_d = WAIT_H;
                cnt_d   = GAP_M1;
            end
            WAIT_H: begin
                if (cnt_q == 4'd0) state_d = WR_H;
                else               cnt_d   = cnt_q - 4'd1;
            end
            WR_H:  state_d = FRZ_L;
            FRZ_L: begin
                state_d = WAIT_L;
                cnt_d   = GAP_M1;
            end
            WAIT_L: begin
                if (cnt_q == 4'd0) state_d = WR_L;
                else               cnt_d   = cnt_q - 4'd1;
            end
            WR_L:    state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tos_o       = 32'h0;
        set_chan_o  = 1'b0;
        freeze_o    = 1'b0;
        set_freqH_o = 1'b0;
        set_freqL_o = 1'b0;
        rx_ack_c    = 1'b0;
        wf_ack_c    = 1'b0;
        kind_o      = (state_q != IDLE) ? kind_q : 1'b0;
        busy        = (state_q != IDLE);
        unique case (state_q)
            SEL: begin
                set_chan_o = 1'b1;
                tos_o      = 32'(chan_q);
            end
            FRZ_H: begin
                freeze_o = 1'b1;
                tos_o    = {16'b0, freq_q[47:32]};
            end
            WAIT_H: tos_o = {16'b0, freq_q[47:32]};
            WR_H: begin
                set_freqH_o = 1'b1;
                tos_o       = {16'b0, freq_q[47:32]};
            end
            FRZ_L: begin
                freeze_o = 1'b1;
                tos_o    = freq_q[31:0];
            end
            WAIT_L: tos_o = freq_q[31:0];
            WR_L: begin
                set_freqL_o = 1'b1;
                tos_o       = freq_q[31:0];
            end
            ACK: begin
                rx_ack_c = (kind_q == KIND_RX);
                wf_ack_c = (kind_q == KIND_WF);
            end
            default: ;
        endcase
    end

    assign rx.ack = rx_ack_c;
    assign wf.ack = wf_ack_c;

endmodule

// File: tb/tb_rx_freq_sched.sv
// Directed bench for rx_freq_sched: expected strobe events are queued when
// requests are driven and matched cycle-by-cycle against the DUT outputs.
module tb_rx_freq_sched;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   nchk  = 0;
    int   nfail = 0;

    typedef struct {
        int          cyc;
        int          typ;
        logic [31:0] tos;
        logic        kind;
    } ev_t;

    ev_t sb0[$];
    ev_t sb1[$];

    rx_freq_sched_if #(.CHAN_BITS(3)) rx0 ();
    rx_freq_sched_if #(.CHAN_BITS(3)) wf0 ();
    rx_freq_sched_if #(.CHAN_BITS(3)) rx3 ();
    rx_freq_sched_if #(.CHAN_BITS(3)) wf3 ();

    logic [31:0] tos0, tos3;
    logic kind0, sc0, fz0, fh0, fl0, busy0;
    logic kind3, sc3, fz3, fh3, fl3, busy3;

    rx_freq_sched #(.CHAN_BITS(3), .SYNC_GAP(4)) u_dut0 (
        .cpu_clk(clk), .rst_n(rst_n), .rx(rx0), .wf(wf0),
        .tos_o(tos0), .kind_o(kind0), .set_chan_o(sc0), .freeze_o(fz0),
        .set_freqH_o(fh0), .set_freqL_o(fl0), .busy(busy0)
    );

    rx_freq_sched #(.CHAN_BITS(3), .SYNC_GAP(3)) u_dut3 (
        .cpu_clk(clk), .rst_n(rst_n), .rx(rx3), .wf(wf3),
        .tos_o(tos3), .kind_o(kind3), .set_chan_o(sc3), .freeze_o(fz3),
        .set_freqH_o(fh3), .set_freqL_o(fl3), .busy(busy3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // typ: 0 chan, 1 freeze, 2 freqH, 3 freqL, 4 rx_ack, 5 wf_ack
    function automatic void expect_seq(input int d, input int n,
                                       input logic k, input logic [2:0] ch,
                                       input logic [47:0] f, input int g);
        ev_t e[6];
        logic [31:0] hi;
        logic [31:0] lo;
        hi = {16'b0, f[47:32]};
        lo = f[31:0];
        e[0] = '{cyc: n + 1,         typ: 0, tos: {29'b0, ch}, kind: k};
        e[1] = '{cyc: n + 2,         typ: 1, tos: hi,          kind: k};
        e[2] = '{cyc: n + 3 + g,     typ: 2, tos: hi,          kind: k};
        e[3] = '{cyc: n + 4 + g,     typ: 1, tos: lo,          kind: k};
        e[4] = '{cyc: n + 5 + 2 * g, typ: 3, tos: lo,          kind: k};
        e[5] = '{cyc: n + 6 + 2 * g, typ: k ? 5 : 4, tos: 32'h0, kind: k};
        for (int i = 0; i < 6; i++) begin
            if (d == 0) sb0.push_back(e[i]);
            else        sb1.push_back(e[i]);
        end
    endfunction

    task automatic mon(input int d, input logic sc, input logic fz,
                       input logic fh, input logic fl, input logic ra,
                       input logic wa, input logic [31:0] tos,
                       input logic kind, input logic busy);
        int n;
        int typ;
        bit due;
        ev_t e;
        string t;
        n = int'(sc) + int'(fz) + int'(fh) + int'(fl) + int'(ra) + int'(wa);
        typ = -1;
        if (n > 1)   typ = 7;
        else if (sc) typ = 0;
        else if (fz) typ = 1;
        else if (fh) typ = 2;
        else if (fl) typ = 3;
        else if (ra) typ = 4;
        else if (wa) typ = 5;
        if (d == 0) due = (sb0.size() > 0) && (sb0[0].cyc == cyc);
        else        due = (sb1.size() > 0) && (sb1[0].cyc == cyc);
        t = $sformatf("dut%0d cyc%0d", d, cyc);
        if (due) begin
            if (d == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
            chk({t, " strobe"}, typ, e.typ);
            chk({t, " tos"}, tos, e.tos);
            chk({t, " kind"}, {31'b0, kind}, {31'b0, e.kind});
            chk({t, " busy"}, {31'b0, busy}, 32'd1);
        end else if (n > 0) begin
            chk({t, " stray strobe"}, typ, -1);
        end
    endtask

    always @(negedge clk) begin
        mon(0, sc0, fz0, fh0, fl0, rx0.ack, wf0.ack, tos0, kind0, busy0);
        mon(1, sc3, fz3, fh3, fl3, rx3.ack, wf3.ack, tos3, kind3, busy3);
    end

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " tos0"}, tos0, 32'h0);
        chk({tag, " kind0"}, {31'b0, kind0}, 32'h0);
        chk({tag, " chan0"}, {31'b0, sc0}, 32'h0);
        chk({tag, " frz0"}, {31'b0, fz0}, 32'h0);
        chk({tag, " fh0"}, {31'b0, fh0}, 32'h0);
        chk({tag, " fl0"}, {31'b0, fl0}, 32'h0);
        chk({tag, " busy0"}, {31'b0, busy0}, 32'h0);
        chk({tag, " rxack0"}, {31'b0, rx0.ack}, 32'h0);
        chk({tag, " wfack0"}, {31'b0, wf0.ack}, 32'h0);
        chk({tag, " tos3"}, tos3, 32'h0);
        chk({tag, " busy3"}, {31'b0, busy3}, 32'h0);
    endtask

    initial begin
        int n;
        rx0.req = 1'b0; rx0.chan = '0; rx0.freq = '0;
        wf0.req = 1'b0; wf0.chan = '0; wf0.freq = '0;
        rx3.req = 1'b0; rx3.chan = '0; rx3.freq = '0;
        wf3.req = 1'b0; wf3.chan = '0; wf3.freq = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        rst_n = 1'b1;
        at(cyc + 2);
        chk_idle("idle");

        // single RX request
        n = cyc;
        rx0.chan = 3'd5;
        rx0.freq = 48'h1234_89AB_CDEF;
        rx0.req  = 1'b1;
        expect_seq(0, n, 1'b0, 3'd5, 48'h1234_89AB_CDEF, 4);
        at(n + 4);
        chk("t1 wait tos", tos0, 32'h0000_1234);
        chk("t1 wait busy", {31'b0, busy0}, 32'd1);
        at(n + 15);
        rx0.req = 1'b0;
        chk("t1 busy after ack", {31'b0, busy0}, 32'h0);
        chk("t1 tos after ack", tos0, 32'h0);

        // both requests from reset release, held continuously
        rst_n = 1'b0;
        rx0.chan = 3'd1;
        rx0.freq = 48'hA5A5_0F0F_1234;
        wf0.chan = 3'd7;
        wf0.freq = 48'hFFFF_FFFF_FFFF;
        rx0.req  = 1'b1;
        wf0.req  = 1'b1;
        at(cyc + 2);
        rst_n = 1'b1;
        n = cyc;
        expect_seq(0, n, 1'b0, 3'd1, 48'hA5A5_0F0F_1234, 4);
        expect_seq(0, n + 15, 1'b1, 3'd7, 48'hFFFF_FFFF_FFFF, 4);
        expect_seq(0, n + 30, 1'b0, 3'd1, 48'hA5A5_0F0F_1234, 4);
        at(n + 20);
        chk("t2 wf kind", {31'b0, kind0}, 32'd1);
        at(n + 45);
        rx0.req = 1'b0;
        wf0.req = 1'b0;
        at(n + 47);
        chk("t2 idle busy", {31'b0, busy0}, 32'h0);

        // WF arrives during RX WAIT_H, inputs change before grant
        n = cyc;
        rx0.chan = 3'd2;
        rx0.freq = 48'h0001_0002_0003;
        rx0.req  = 1'b1;
        expect_seq(0, n, 1'b0, 3'd2, 48'h0001_0002_0003, 4);
        at(n + 4);
        wf0.chan = 3'd1;
        wf0.freq = 48'h1111_2222_3333;
        wf0.req  = 1'b1;
        at(n + 5);
        wf0.chan = 3'd6;
        wf0.freq = 48'hDEAD_BEEF_CAFE;
        expect_seq(0, n + 15, 1'b1, 3'd6, 48'hDEAD_BEEF_CAFE, 4);
        at(n + 15);
        rx0.req = 1'b0;
        at(n + 30);
        wf0.req = 1'b0;
        at(n + 32);
        chk("t3 idle busy", {31'b0, busy0}, 32'h0);

        // reset pulse during WAIT_L aborts, held request restarts
        n = cyc;
        rx0.chan = 3'd3;
        rx0.freq = 48'hCAFE_0123_4567;
        rx0.req  = 1'b1;
        expect_seq(0, n, 1'b0, 3'd3, 48'hCAFE_0123_4567, 4);
        at(n + 10);
        chk("t4 pre-reset tos", tos0, 32'h0123_4567);
        rst_n = 1'b0;
        sb0.delete();
        #1;
        chk_idle("mid reset");
        at(n + 12);
        rst_n = 1'b1;
        expect_seq(0, n + 12, 1'b0, 3'd3, 48'hCAFE_0123_4567, 4);
        at(n + 27);
        rx0.req = 1'b0;
        at(n + 29);
        chk_idle("t4 end");

        // SYNC_GAP=3 build, max-width values
        n = cyc;
        rx3.chan = 3'd7;
        rx3.freq = 48'hFFFF_FFFF_FFFF;
        rx3.req  = 1'b1;
        expect_seq(1, n, 1'b0, 3'd7, 48'hFFFF_FFFF_FFFF, 3);
        at(n + 5);
        chk("t5 wait tos", tos3, 32'h0000_FFFF);
        at(n + 13);
        rx3.req = 1'b0;
        n = cyc;
        wf3.chan = 3'd4;
        wf3.freq = 48'h0F0F_8000_0001;
        wf3.req  = 1'b1;
        expect_seq(1, n, 1'b1, 3'd4, 48'h0F0F_8000_0001, 3);
        at(n + 13);
        wf3.req = 1'b0;
        at(n + 15);
        chk("t5 busy3", {31'b0, busy3}, 32'h0);

        chk("sb0 drained", sb0.size(), 32'h0);
        chk("sb1 drained", sb1.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
